// File: rtl/ioctl_upload_ctrl.sv
// HPS upload bridge: pauses the game core, then serves byte reads from the game RAM
// second port with a fixed read latency, padding out-of-window addresses with 0xFF.
module ioctl_upload_ctrl #(
    parameter int unsigned AW     = 14,
    parameter int unsigned SIZE   = 1024,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_data,
    output logic          done,
    output logic [AW:0]   byte_count
);

    typedef enum logic [1:0] {StIdle, StPause, StReady, StFetch} state_e;

    localparam logic [AW:0] SizeLim = (AW + 1)'(SIZE);
    localparam logic [2:0]  LatInit = 3'(RD_LAT);

    state_e          state_q, state_d;
    logic            upload_q;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      din_q, din_d;
    logic [AW:0]     count_q, count_d;
    logic [AW:0]     count_inc;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_rd_q, mem_rd_d;
    logic            done_q, done_d;
    logic            in_range;

    assign in_range  = ({1'b0, ioctl_addr} < SizeLim);
    assign count_inc = (&count_q) ? count_q : count_q + (AW + 1)'(1);

    // upload_q resets high so a level already present at reset release is not a start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            upload_q   <= 1'b1;
            cnt_q      <= '0;
            din_q      <= '0;
            count_q    <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            upload_q   <= ioctl_upload;
            cnt_q      <= cnt_d;
            din_q      <= din_d;
            count_q    <= count_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        din_d      = din_q;
        count_d    = count_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (ioctl_upload && !upload_q) begin
                    state_d = StPause;
                    count_d = '0;
                end
            end
            StPause: begin
                if (!ioctl_upload) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (pause_ack) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (!ioctl_upload) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (ioctl_rd) begin
                    if (in_range) begin
                        mem_addr_d = ioctl_addr;
                        mem_rd_d   = 1'b1;
                        cnt_d      = LatInit;
                        state_d    = StFetch;
                    end else begin
                        din_d   = 8'hFF;
                        count_d = count_inc;
                    end
                end
            end
            StFetch: begin
                // an abort drops the in-flight byte; din and count keep their values
                if (!ioctl_upload) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (cnt_q == 3'd0) begin
                    din_d   = mem_data;
                    count_d = count_inc;
                    state_d = StReady;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pause_req  = (state_q != StIdle);
    assign ioctl_wait = (state_q == StPause) || (state_q == StFetch);
    assign ioctl_din  = din_q;
    assign byte_count = count_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ioctl_upload_ctrl.sv
// Directed bench for ioctl_upload_ctrl: default instance with a latency-2 RAM model, plus a
// tiny AW=2 instance for latency-1 timing and byte_count saturation.
module tb_ioctl_upload_ctrl;

    localparam int AW     = 14;
    localparam int SIZE   = 1024;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          ioctl_upload, ioctl_rd, pause_ack;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait, pause_req, mem_rd, done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [AW:0]   byte_count;

    logic          s_upload, s_rd, s_ack;
    logic [1:0]    s_addr;
    logic [7:0]    s_din;
    logic          s_wait, s_pause_req, s_mem_rd, s_done;
    logic [1:0]    s_mem_addr;
    logic [2:0]    s_count;
    logic [7:0]    s_mem_data;

    int n_cmp = 0;
    int n_err = 0;
    int n_memrd = 0;
    int n_done = 0;

    logic [7:0] ram [0:(1<<AW)-1];
    logic [7:0] pipe [0:RD_LAT-1];

    always #5 clk = ~clk;

    ioctl_upload_ctrl #(.AW(AW), .SIZE(SIZE), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .pause_req(pause_req), .pause_ack(pause_ack), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .done(done), .byte_count(byte_count)
    );

    ioctl_upload_ctrl #(.AW(2), .SIZE(2), .RD_LAT(1)) dut_s (
        .clk(clk), .reset(reset), .ioctl_upload(s_upload), .ioctl_rd(s_rd),
        .ioctl_addr(s_addr), .ioctl_din(s_din), .ioctl_wait(s_wait),
        .pause_req(s_pause_req), .pause_ack(s_ack), .mem_addr(s_mem_addr), .mem_rd(s_mem_rd),
        .mem_data(s_mem_data), .done(s_done), .byte_count(s_count)
    );

    assign s_mem_data = 8'h3C;

    // RAM model: data appears exactly RD_LAT cycles after mem_rd, filler otherwise
    always @(posedge clk) begin
        pipe[0] <= mem_rd ? ram[mem_addr] : 8'hEE;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        if (mem_rd) n_memrd <= n_memrd + 1;
        if (done) n_done <= n_done + 1;
    end
    assign mem_data = pipe[RD_LAT-1];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [7:0] exp_din,
                           input logic [AW:0] exp_cnt);
        int m0;
        logic [7:0] prev_din;
        m0 = n_memrd;
        prev_din = ioctl_din;
        ioctl_rd = 1'b1;
        ioctl_addr = a;
        tick(1);
        ioctl_rd = 1'b0;
        check("rd_mem_rd", mem_rd, 1);
        check("rd_mem_addr", mem_addr, a);
        for (int i = 0; i < RD_LAT + 1; i++) begin
            check("rd_wait_hi", ioctl_wait, 1);
            check("rd_din_hold", ioctl_din, prev_din);
            tick(1);
        end
        check("rd_wait_lo", ioctl_wait, 0);
        check("rd_din", ioctl_din, exp_din);
        check("rd_count", byte_count, exp_cnt);
        check("rd_one_mem_rd", n_memrd, m0 + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int m0;
        int d0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = i[7:0] ^ 8'h5A;
        ram[5] = 8'hA5;
        reset = 1'b1;
        ioctl_upload = 1'b1;
        ioctl_rd = 1'b0;
        ioctl_addr = '0;
        pause_ack = 1'b0;
        s_upload = 1'b0;
        s_rd = 1'b0;
        s_addr = '0;
        s_ack = 1'b0;
        tick(2);
        check("rst_din", ioctl_din, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_pause_req", pause_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_done", done, 0);
        check("rst_count", byte_count, 0);

        // upload already high at release: no session
        reset = 1'b0;
        tick(3);
        check("no_start_level", pause_req, 0);
        ioctl_upload = 1'b0;
        tick(2);

        // session start with a 5-cycle pause_ack stall
        ioctl_upload = 1'b1;
        tick(1);
        check("start_pause_req", pause_req, 1);
        check("start_wait", ioctl_wait, 1);
        check("start_count", byte_count, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("stall_pause_req", pause_req, 1);
            check("stall_wait", ioctl_wait, 1);
        end
        pause_ack = 1'b1;
        tick(1);
        check("ready_wait", ioctl_wait, 0);
        check("ready_pause_req", pause_req, 1);

        do_read(14'h005, 8'hA5, 15'd1);

        // out of range
        m0 = n_memrd;
        ioctl_rd = 1'b1;
        ioctl_addr = 14'h400;
        tick(1);
        ioctl_rd = 1'b0;
        check("oor_din", ioctl_din, 8'hFF);
        check("oor_count", byte_count, 2);
        check("oor_wait", ioctl_wait, 0);
        check("oor_mem_rd", mem_rd, 0);
        tick(1);
        check("oor_no_mem_rd", n_memrd, m0);

        do_read(14'h3FF, 8'hA5, 15'd3);

        // strobe during FETCH is ignored
        m0 = n_memrd;
        ioctl_rd = 1'b1;
        ioctl_addr = 14'h010;
        tick(1);
        ioctl_addr = 14'h020;
        tick(1);
        ioctl_rd = 1'b0;
        tick(2);
        check("ill_din", ioctl_din, 8'h4A);
        check("ill_count", byte_count, 4);
        check("ill_wait", ioctl_wait, 0);
        tick(1);
        check("ill_one_mem_rd", n_memrd, m0 + 1);
        check("ill_count_after", byte_count, 4);

        // pause_ack dropping in READY changes nothing
        pause_ack = 1'b0;
        tick(1);
        check("ack_lo_pause_req", pause_req, 1);
        check("ack_lo_wait", ioctl_wait, 0);
        do_read(14'h0A1, 8'hFB, 15'd5);

        // abort one cycle after mem_rd
        d0 = n_done;
        ioctl_rd = 1'b1;
        ioctl_addr = 14'h030;
        tick(1);
        ioctl_rd = 1'b0;
        check("ab_mem_rd", mem_rd, 1);
        tick(1);
        ioctl_upload = 1'b0;
        tick(1);
        check("ab_done", done, 1);
        check("ab_pause_req", pause_req, 0);
        check("ab_wait", ioctl_wait, 0);
        check("ab_din", ioctl_din, 8'hFB);
        check("ab_count", byte_count, 5);
        tick(1);
        check("ab_done_end", done, 0);
        tick(3);
        check("ab_din_hold", ioctl_din, 8'hFB);
        check("ab_count_hold", byte_count, 5);
        check("ab_one_done", n_done, d0 + 1);

        // full dump
        ram[5] = 8'h5F;
        pause_ack = 1'b1;
        ioctl_upload = 1'b1;
        tick(1);
        check("dump_count_clr", byte_count, 0);
        tick(1);
        for (int i = 0; i < SIZE; i++) begin
            ioctl_rd = 1'b1;
            ioctl_addr = AW'(i);
            tick(1);
            ioctl_rd = 1'b0;
            tick(RD_LAT + 1);
            check("dump_byte", ioctl_din, i[7:0] ^ 8'h5A);
        end
        check("dump_count", byte_count, SIZE);
        ioctl_upload = 1'b0;
        tick(1);
        check("dump_done", done, 1);
        check("dump_count_done", byte_count, SIZE);

        // reset mid-FETCH: no done
        tick(1);
        ioctl_upload = 1'b1;
        tick(2);
        d0 = n_done;
        ioctl_rd = 1'b1;
        ioctl_addr = 14'h007;
        tick(1);
        ioctl_rd = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_done", done, 0);
        check("mid_rst_wait", ioctl_wait, 0);
        check("mid_rst_mem_rd", mem_rd, 0);
        check("mid_rst_din", ioctl_din, 0);
        check("mid_rst_count", byte_count, 0);
        tick(2);
        check("mid_rst_no_done", n_done, d0);
        reset = 1'b0;
        tick(3);
        check("mid_rst_no_restart", pause_req, 0);

        // small instance: latency 1 and saturation at 7
        s_upload = 1'b1;
        tick(1);
        s_ack = 1'b1;
        tick(1);
        s_rd = 1'b1;
        s_addr = 2'd1;
        tick(1);
        s_rd = 1'b0;
        check("s_wait1", s_wait, 1);
        check("s_mem_rd", s_mem_rd, 1);
        tick(1);
        check("s_wait2", s_wait, 1);
        tick(1);
        check("s_wait_lo", s_wait, 0);
        check("s_din", s_din, 8'h3C);
        check("s_count1", s_count, 1);
        s_rd = 1'b1;
        s_addr = 2'd3;
        tick(8);
        s_rd = 1'b0;
        check("s_sat", s_count, 7);
        check("s_oor_din", s_din, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
